// File: rtl/jericalla_fetch.sv
// rtl/jericalla_fetch.sv - instruction fetch stage with local BZ/HALT resolution
module jericalla_fetch #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int IW    = 18
) (
  input  logic          clk_jericalla,
  input  logic          rst_n_jericalla,
  input  logic          start,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          zf_jericalla,
  input  logic          instr_ready,
  output logic [IW-1:0] instruccion,
  output logic          instr_valid,
  output logic [AW-1:0] pc_jericalla,
  output logic          halted,
  output logic [15:0]   issued_count
);

  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_BZ   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_BRANCH,
    S_HALTED
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_word;
  logic [2:0]    rd_op;
  logic          ctl_open;
  logic          accept;
  logic [AW-1:0] pc_plus1;

  // Loads and start are only meaningful while the stage is not running a program.
  assign ctl_open = (state == S_IDLE) || (state == S_HALTED);
  assign accept   = (state == S_ISSUE) && instr_ready;
  assign rd_op    = rd_word[IW-1:IW-3];
  assign pc_plus1 = pc_jericalla + AW'(1);
  assign halted   = (state == S_HALTED);

  // State register.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: control opcodes are consumed here and never reach ISSUE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (rd_op == OP_HALT)    state_nxt = S_HALTED;
        else if (rd_op == OP_BZ) state_nxt = S_BRANCH;
        else                     state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) state_nxt = S_FETCH;
      end
      S_BRANCH: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Program memory: gated write port, read address sampled in FETCH; contents survive reset.
  always_ff @(posedge clk_jericalla) begin
    if (load_we && ctl_open) mem[load_addr] <= load_data;
    if (state == S_FETCH)    rd_word <= mem[pc_jericalla];
  end

  // Program counter: restart at 0, step on accept, resolve BZ with the flag seen in BRANCH.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      pc_jericalla <= '0;
    end else if (ctl_open && start) begin
      pc_jericalla <= '0;
    end else if (accept) begin
      pc_jericalla <= pc_plus1;
    end else if (state == S_BRANCH) begin
      pc_jericalla <= zf_jericalla ? instruccion[AW-1:0] : pc_plus1;
    end
  end

  // Output word: captured in DECODE (also for BZ, whose target is read back from it), held otherwise.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      instruccion <= '0;
      instr_valid <= 1'b0;
    end else if (state == S_DECODE) begin
      instruccion <= rd_word;
      instr_valid <= (rd_op != OP_HALT) && (rd_op != OP_BZ);
    end else if (accept) begin
      instr_valid <= 1'b0;
    end
  end

  // Accepted-instruction counter, saturating; only reset clears it.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      issued_count <= '0;
    end else if (accept && (issued_count != 16'hFFFF)) begin
      issued_count <= issued_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_jericalla_fetch.sv
// tb/tb_jericalla_fetch.sv - self-checking bench for jericalla_fetch
module tb_jericalla_fetch;

  localparam logic [17:0] W0   = 18'b000001000000100000;
  localparam logic [17:0] W1   = 18'b001001010000100010;
  localparam logic [17:0] HALT = 18'b110000000000000000;
  localparam logic [17:0] BZ   = 18'b111000000000000000;
  localparam logic [17:0] D5   = 18'h2ABCD;
  localparam logic [17:0] DX   = 18'h12345;
  localparam logic [17:0] D2   = 18'h0F0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_we = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [17:0] load_data = '0;
  logic        zf = 1'b0;
  logic        ready = 1'b0;
  logic [17:0] instruccion;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        halted;
  logic [15:0] issued_count;

  always #5 clk = ~clk;

  jericalla_fetch #(.DEPTH(64), .AW(6), .IW(18)) dut (
    .clk_jericalla  (clk),
    .rst_n_jericalla(rst_n),
    .start          (start),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .zf_jericalla   (zf),
    .instr_ready    (ready),
    .instruccion    (instruccion),
    .instr_valid    (instr_valid),
    .pc_jericalla   (pc),
    .halted         (halted),
    .issued_count   (issued_count)
  );

  int total = 0;
  int bad = 0;
  int ctl_seen = 0;
  int first_valid_cyc;
  int timed_out;
  int hold_err;

  logic [17:0] beat_q[$];
  logic [5:0]  beat_pc_q[$];
  int          beat_cyc_q[$];

  logic [17:0] mdl_mem[64];
  logic [17:0] exp_q[$];
  logic [5:0]  exp_pc_q[$];
  bit          exp_halt;
  logic [5:0]  exp_halt_pc;
  bit          model_ok;

  typedef struct {
    logic [3:0][17:0] w;
    bit               zf;
    int               n;
    logic [17:0]      first;
    logic [5:0]       hpc;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; load_we = 1'b0; ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic [5:0] a, input logic [17:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  function automatic logic [17:0] bd(input int i);
    return (i < beat_q.size()) ? beat_q[i] : 18'h0;
  endfunction

  function automatic logic [5:0] bp(input int i);
    return (i < beat_pc_q.size()) ? beat_pc_q[i] : 6'h3F;
  endfunction

  function automatic int bc(input int i);
    return (i < beat_cyc_q.size()) ? beat_cyc_q[i] : -1000;
  endfunction

  // Pulse start, then watch the handshake; cycle 0 is the first cycle after the start edge.
  task automatic run(input int ready_pct, input int max_cyc, input int max_beats, input int poke_cyc);
    int cyc;
    logic v, pv, pr;
    logic [17:0] d, pd;
    logic [5:0] p, pp;
    beat_q.delete(); beat_pc_q.delete(); beat_cyc_q.delete();
    first_valid_cyc = -1; timed_out = 0; hold_err = 0;
    pv = 1'b0; pr = 1'b1; pd = '0; pp = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!halted && beat_q.size() < max_beats) begin
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      ready = ($urandom_range(99) < ready_pct);
      if (cyc == poke_cyc) begin
        load_we = 1'b1; load_addr = 6'd1; load_data = '0; start = 1'b1; ready = 1'b0;
      end
      v = instr_valid; d = instruccion; p = pc;
      if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (v && d[17:16] == 2'b11) ctl_seen++;
      if (pv && !pr && (!v || d !== pd || p !== pp)) hold_err++;
      pv = v; pr = ready; pd = d; pp = p;
      tick();
      cyc++;
      load_we = 1'b0; start = 1'b0;
      if (v && pr) begin
        beat_q.push_back(d); beat_pc_q.push_back(p); beat_cyc_q.push_back(cyc);
      end
    end
    ready = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc);
    int c;
    c = 0;
    ready = 1'b1;
    while (!halted && c < max_cyc) begin
      tick();
      c++;
    end
    ready = 1'b0;
    check("halt_reached", halted, 1);
  endtask

  // Instruction-level reference: walk the program word by word, no notion of cycles.
  task automatic model_run(input bit zfv, input int max_issue);
    int mpc;
    logic [17:0] w;
    exp_q.delete(); exp_pc_q.delete();
    exp_halt = 0; exp_halt_pc = '0; model_ok = 0;
    mpc = 0;
    for (int steps = 0; steps < 400 && !model_ok; steps++) begin
      w = mdl_mem[mpc];
      if (w[17:15] == 3'b110) begin
        exp_halt = 1; exp_halt_pc = 6'(mpc); model_ok = 1;
      end else if (w[17:15] == 3'b111) begin
        mpc = zfv ? int'(w[5:0]) : (mpc + 1) % 64;
      end else begin
        exp_q.push_back(w); exp_pc_q.push_back(6'(mpc));
        mpc = (mpc + 1) % 64;
        if (exp_q.size() == max_issue) model_ok = 1;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    logic [17:0] w;
    bit rz;

    vt[0] = '{w: {HALT, HALT, W1, W0},        zf: 1'b0, n: 2, first: W0, hpc: 6'd2};
    vt[1] = '{w: {HALT, W1, W0, HALT},        zf: 1'b1, n: 0, first: '0, hpc: 6'd0};
    vt[2] = '{w: {HALT, HALT, W0, BZ | 18'd3}, zf: 1'b1, n: 0, first: '0, hpc: 6'd3};
    vt[3] = '{w: {HALT, HALT, W0, BZ | 18'd3}, zf: 1'b0, n: 1, first: W0, hpc: 6'd2};
    vt[4] = '{w: {HALT, HALT, BZ, D5},        zf: 1'b0, n: 1, first: D5, hpc: 6'd2};
    vt[5] = '{w: {HALT, W0, BZ | 18'd3, W1},   zf: 1'b1, n: 1, first: W1, hpc: 6'd3};

    // Reset state
    repeat (3) tick();
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_count", issued_count, 0);
    check("rst_instr", instruccion, 0);
    rst_n = 1'b1;
    tick();

    // Load and run
    load(6'd0, W0); load(6'd1, W1); load(6'd2, HALT);
    run(100, 100, 10, -1);
    check("a_timeout", timed_out, 0);
    check("a_beats", beat_q.size(), 2);
    check("a_beat0", bd(0), W0);
    check("a_beat1", bd(1), W1);
    check("a_gap", bc(1) - bc(0), 3);
    check("a_latency", first_valid_cyc, 2);
    check("a_halted", halted, 1);
    check("a_pc", pc, 2);
    check("a_count", issued_count, 2);

    // Backpressure during the first ISSUE
    ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("b_hold_word", {instr_valid, instruccion}, {1'b1, W0});
      check("b_hold_pc_cnt", {pc, issued_count}, {6'd0, 16'd2});
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("b_accept_cnt", issued_count, 3);
    check("b_accept_pc", pc, 1);
    check("b_accept_valid", instr_valid, 0);
    wait_halt(50);
    check("b_final_cnt", issued_count, 4);

    // load_we and start during ISSUE are ignored
    run(100, 100, 10, 2);
    check("c_beats", beat_q.size(), 2);
    check("c_beat1", bd(1), W1);
    check("c_pc", pc, 2);
    run(100, 100, 10, -1);
    check("c_rerun_beat1", bd(1), W1);
    check("c_count", issued_count, 8);

    // Reset mid-ISSUE
    ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("f_pre_valid", instr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_async_valid", instr_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("f_pc", pc, 0);
    check("f_count", issued_count, 0);
    check("f_halted", halted, 0);
    check("f_instr", instruccion, 0);
    run(100, 100, 10, -1);
    check("f_replay_beats", beat_q.size(), 2);
    check("f_replay_beat0", bd(0), W0);
    check("f_replay_count", issued_count, 2);

    // Branch taken / not taken
    load(6'd2, D2); load(6'd3, BZ | 18'd5); load(6'd4, DX); load(6'd5, D5); load(6'd6, HALT);
    zf = 1'b1;
    run(100, 200, 10, -1);
    check("d_t_beats", beat_q.size(), 4);
    check("d_t_beat3", bd(3), D5);
    check("d_t_pc3", bp(3), 5);
    check("d_t_gap", bc(3) - bc(2), 6);
    check("d_t_hpc", pc, 6);
    zf = 1'b0;
    run(100, 200, 10, -1);
    check("d_n_beats", beat_q.size(), 5);
    check("d_n_beat3", bd(3), DX);
    check("d_n_pc3", bp(3), 4);
    check("d_n_beat4", bd(4), D5);
    check("d_n_hpc", pc, 6);

    // PC wrap from 63 to 0
    load(6'd0, BZ | 18'd62); load(6'd1, HALT); load(6'd62, DX); load(6'd63, D5);
    zf = 1'b1;
    run(100, 200, 2, -1);
    check("e_pc0", bp(0), 62);
    check("e_pc1", bp(1), 63);
    check("e_wrap_pc", pc, 0);
    zf = 1'b0;
    wait_halt(50);
    check("e_hpc", pc, 1);

    // Table-driven short programs
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < 4; k++) load(6'(k), vt[i].w[k]);
      zf = vt[i].zf;
      run(100, 200, 10, -1);
      check($sformatf("v%0d_beats", i), beat_q.size(), vt[i].n);
      check($sformatf("v%0d_first", i), bd(0), vt[i].first);
      check($sformatf("v%0d_halted", i), halted, 1);
      check($sformatf("v%0d_hpc", i), pc, vt[i].hpc);
      check($sformatf("v%0d_count", i), issued_count, vt[i].n);
    end

    // Random programs, random stalls, against the instruction-level model
    for (int r = 0; r < 8; r++) begin
      do begin
        for (int a = 0; a < 64; a++) begin
          s = $urandom_range(15);
          w = 18'($urandom);
          if (s == 0)     w[17:15] = 3'b110;
          else if (s < 4) w[17:15] = 3'b111;
          else            w[17:15] = 3'($urandom_range(5));
          mdl_mem[a] = w;
        end
        rz = 1'($urandom_range(1));
        model_run(rz, 12);
      end while (!model_ok);
      do_reset();
      for (int a = 0; a < 64; a++) load(6'(a), mdl_mem[a]);
      zf = rz;
      run(60, 3000, 12, -1);
      check($sformatf("r%0d_timeout", r), timed_out, 0);
      check($sformatf("r%0d_beats", r), beat_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("r%0d_word%0d", r, i), bd(i), exp_q[i]);
        check($sformatf("r%0d_pc%0d", r, i), bp(i), exp_pc_q[i]);
      end
      check($sformatf("r%0d_halted", r), halted, exp_halt);
      if (exp_halt) check($sformatf("r%0d_hpc", r), pc, exp_halt_pc);
      check($sformatf("r%0d_count", r), issued_count, exp_q.size());
      check($sformatf("r%0d_stall_hold", r), hold_err, 0);
    end

    check("ctl_never_valid", ctl_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
